mem_dump_unit: RTL and testbench
================================

// Module: mem_dump_unit
// PURPOSE
//  Reader side of the MEM-stage data memory, used by the debug path. On a start
//  pulse it walks every data-memory word from address 0 upward, reading each over
//  the memory's MemRead/address/read_data interface. It serialises each word into
//  bytes for the UART transmitter, MSB first, and handshakes one byte at a time.
//  It runs only while the pipeline is halted and is the sole MemRead driver then.
// PARAMETERS
//  DATA_BITS   32  data-memory word width; must be a multiple of 8
//  ADDR_BITS   32  data-memory address width; the address is a word index
//  MEM_DEPTH   32  number of words dumped (addresses 0 .. MEM_DEPTH-1)
//  (derived localparam) BYTES_PER_WORD = DATA_BITS/8
// PORTS
//  clk           in   1          system clock, rising edge
//  rst           in   1          reset, asynchronous, active-high
//  i_start       in   1          one-cycle request to begin a dump
//  o_mem_read    out  1          MemRead to data memory
//  o_mem_address out  ADDR_BITS  word address to data memory
//  i_mem_data    in   DATA_BITS  read data from data memory
//  o_tx_data     out  8          byte for the UART transmitter
//  o_tx_start    out  1          one-cycle pulse: o_tx_data is valid, send it
//  i_tx_done     in   1          one-cycle pulse from UART TX: byte sent
//  o_busy        out  1          high from the cycle after i_start until DONE
//  o_done        out  1          one-cycle pulse: dump complete
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, addr=0, byte_cnt=0, word_reg=0;
//    all outputs are 0. No partial dump is resumed; the next start begins at addr 0.
//  - FSM states: IDLE, READ, CAPTURE, SEND, WAIT_TX, NEXT, DONE.
//    Outputs are decoded from registered state and registers (Moore).
//  - IDLE: if i_start, then addr<=0 and go to READ. i_tx_done is ignored.
//  - READ (1 cycle): o_mem_read=1, o_mem_address=addr. Go to CAPTURE.
//    The memory returns data on the falling edge, so it is valid by the next rising edge.
//  - CAPTURE (1 cycle): word_reg<=i_mem_data, byte_cnt<=0. Go to SEND.
//    o_mem_read=0, and o_mem_address holds addr.
//  - SEND (1 cycle): o_tx_start=1, o_tx_data=word_reg[DATA_BITS-1 -: 8]. Go to WAIT_TX.
//  - WAIT_TX: o_tx_data is held stable and o_tx_start=0. Stay until i_tx_done.
//    On i_tx_done with byte_cnt==BYTES_PER_WORD-1, go to NEXT.
//    On i_tx_done otherwise: word_reg<<=8, byte_cnt++, and go to SEND.
//    An i_tx_done seen in any other state (including the SEND cycle) is ignored.
//  - NEXT (1 cycle): if addr==MEM_DEPTH-1, go to DONE (no wrap).
//    Otherwise addr++ and go to READ.
//  - DONE (1 cycle): o_done=1. Go to IDLE.
//  - o_busy=1 in every state except IDLE. i_start while busy is ignored.
//  - i_start in the same cycle as DONE is ignored. A start is accepted only in IDLE.
//  - Output byte order per word is big-endian. Total bytes = MEM_DEPTH*BYTES_PER_WORD.
//  - Latency: i_start at edge N gives o_mem_read=1 in cycle N+1 and the first
//    o_tx_start in cycle N+3. Per word: 3 + BYTES_PER_WORD*(1 + tx wait) cycles.
//  - addr counter width is clog2(MEM_DEPTH), zero-extended onto o_mem_address.
//  - o_mem_read is never high for more than 1 consecutive cycle, and never high
//    outside READ.
// STRUCTURE
//  - Package mem_dump_pkg: state encoding localparams (3-bit), BYTE_BITS=8,
//    and a clog2 function.
//  - Optional sub-module word_serializer: word_reg, byte_cnt, shift/load and
//    last-byte flag. The FSM, address counter and memory interface stay in
//    mem_dump_unit.
// TESTING
//  1. Memory holds reset image ram[i]=i; pulse i_start; the TX model returns
//     i_tx_done 1 cycle after o_tx_start.
//     -> 128 bytes: 00 00 00 00, 00 00 00 01, ..., 00 00 00 1F.
//     -> Exactly 32 o_mem_read pulses, addresses 0..31 ascending, then a
//        single o_done pulse.
//  2. Write 0xDEADBEEF to addr 5 before the dump.
//     -> Bytes 20..23 of the stream are DE AD BE EF; neighbouring words are
//        unchanged.
//  3. The TX model delays i_tx_done by 20 cycles.
//     -> No second o_tx_start before i_tx_done.
//     -> o_tx_data stays constant across every WAIT_TX cycle, and the stream
//        matches test 1.
//  4. Re-pulse i_start during word 7, and pulse i_tx_done during IDLE and
//     READ cycles.
//     -> The dump is unaffected: still 128 correct bytes and one o_done.
//  5. Assert rst mid-cycle during WAIT_TX of word 10.
//     -> All outputs are 0 immediately, before the next edge.
//     -> After release, a new i_start produces a full dump from addr 0.
//  6. Set MEM_DEPTH=4 and DATA_BITS=16.
//     -> 8 bytes, MSB first.
//     -> o_done pulses after addr 3 with no wrap to addr 0.

Source files
------------

// File: rtl/mem_dump_pkg.sv
// Shared definitions for the data-memory dump path: FSM encoding, byte width
// and the ceil-log2 helper used to size the address and byte counters.
package mem_dump_pkg;

    localparam int unsigned BYTE_BITS = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_READ    = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_READ    = ST_READ,
        S_CAPTURE = ST_CAPTURE,
        S_SEND    = ST_SEND,
        S_WAIT_TX = ST_WAIT_TX,
        S_NEXT    = ST_NEXT,
        S_DONE    = ST_DONE
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // A counter over a single value still needs one bit to exist.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/mem_dump_unit_word_serializer.sv
// Holds one captured memory word and presents it a byte at a time, MSB first,
// shifting left by a byte on each advance.
module word_serializer
    import mem_dump_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [DATA_BITS-1:0] word_i,
    output logic [BYTE_BITS-1:0] byte_o,
    output logic                 last_o
);

    localparam int unsigned BYTES_PER_WORD = DATA_BITS / BYTE_BITS;
    localparam int unsigned CNT_W          = cnt_width(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(BYTES_PER_WORD - 1);

    logic [DATA_BITS-1:0] word_q;
    logic [DATA_BITS-1:0] word_d;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [CNT_W-1:0]     byte_cnt_d;

    // Load takes priority over shift; otherwise hold the current word.
    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        if (load_i) begin
            word_d     = word_i;
            byte_cnt_d = '0;
        end else if (shift_i) begin
            word_d     = word_q << BYTE_BITS;
            byte_cnt_d = byte_cnt_q + 1'b1;
        end else begin
            word_d     = word_q;
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Word and byte-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_o = word_q[DATA_BITS-1 -: BYTE_BITS];
    assign last_o = (byte_cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_dump_unit.sv
// Debug-path reader of the data memory: walks every word from address 0 and
// streams it to the UART transmitter one handshaked byte at a time.
module mem_dump_unit
    import mem_dump_pkg::*;
#(
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    output logic                 o_mem_read,
    output logic [ADDR_BITS-1:0] o_mem_address,
    input  logic [DATA_BITS-1:0] i_mem_data,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_start,
    input  logic                 i_tx_done,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned CNT_W         = cnt_width(MEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(MEM_DEPTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] addr_q;
    logic [CNT_W-1:0] addr_d;
    logic             load_s;
    logic             shift_s;
    logic             last_s;

    word_serializer #(
        .DATA_BITS (DATA_BITS)
    ) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .word_i  (i_mem_data),
        .byte_o  (o_tx_data),
        .last_o  (last_s)
    );

    // Next-state and Moore output decode; a start is only honoured in IDLE.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        o_mem_read = 1'b0;
        o_tx_start = 1'b0;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    addr_d  = '0;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                o_mem_read = 1'b1;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                load_s  = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                o_tx_start = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_tx_done) begin
                    if (last_s) begin
                        state_d = S_NEXT;
                    end else begin
                        shift_s = 1'b1;
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_WAIT_TX;
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                o_busy  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and word-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign o_mem_address = ADDR_BITS'(addr_q);

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit: memory and UART models driven at the
// falling edge, byte stream compared against words expanded MSB first.
module tb_mem_dump_unit;

    localparam int DEPTH = 32;
    localparam int BPW   = 4;
    localparam int NBYTES = DEPTH * BPW;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        o_mem_read;
    logic [31:0] o_mem_address;
    logic [31:0] i_mem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    logic        b_start;
    logic        b_mem_read;
    logic [31:0] b_mem_address;
    logic [15:0] b_mem_data;
    logic [7:0]  b_tx_data;
    logic        b_tx_start;
    logic        b_tx_done;
    logic        b_busy;
    logic        b_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [DEPTH];
    logic [15:0] ramb [4];

    logic [7:0] got_b[$];
    int         got_a[$];
    int         done_cnt = 0;
    int         mr_viol = 0;
    int         wait_viol = 0;
    int         tx_delay = 1;
    bit         inj_idle = 1'b0;
    bit         inj_read = 1'b0;
    bit         prev_mr = 1'b0;
    bit         waiting = 1'b0;
    logic [7:0] held = 8'd0;
    int         tx_cnt = 0;

    always #5 clk = ~clk;

    mem_dump_unit #(.DATA_BITS(32), .ADDR_BITS(32), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_mem_read(o_mem_read),
        .o_mem_address(o_mem_address), .i_mem_data(i_mem_data),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_done(o_done)
    );

    mem_dump_unit #(.DATA_BITS(16), .ADDR_BITS(32), .MEM_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .i_start(b_start), .o_mem_read(b_mem_read),
        .o_mem_address(b_mem_address), .i_mem_data(b_mem_data),
        .o_tx_data(b_tx_data), .o_tx_start(b_tx_start), .i_tx_done(b_tx_done),
        .o_busy(b_busy), .o_done(b_done)
    );

    // Memory returns data on the falling edge of a read; the UART acknowledges
    // each byte tx_delay cycles after its start pulse.
    always @(negedge clk) begin
        if (rst) begin
            waiting    = 1'b0;
            tx_cnt     = 0;
            prev_mr    = 1'b0;
            i_tx_done  = 1'b0;
            i_mem_data = 32'd0;
        end else begin
            i_tx_done = 1'b0;
            if (o_mem_read) begin
                got_a.push_back(int'(o_mem_address));
                i_mem_data = ram[o_mem_address[4:0]];
                if (prev_mr) mr_viol++;
            end
            prev_mr = o_mem_read;
            if (o_done) done_cnt++;
            if (waiting) begin
                if (o_tx_start || (o_tx_data !== held)) wait_viol++;
                if (tx_cnt > 0) tx_cnt--;
                if (tx_cnt == 0) begin
                    i_tx_done = 1'b1;
                    waiting   = 1'b0;
                end
            end
            if (o_tx_start) begin
                got_b.push_back(o_tx_data);
                held    = o_tx_data;
                waiting = 1'b1;
                tx_cnt  = tx_delay;
            end
            if ((inj_idle && !o_busy) || (inj_read && o_mem_read)) i_tx_done = 1'b1;
        end
    end

    function automatic logic [7:0] exp_byte(input int idx);
        logic [31:0] w;
        w = ram[idx / BPW];
        return 8'(w >> (8 * (BPW - 1 - (idx % BPW))));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0;
        b_start = 1'b0;
        b_tx_done = 1'b0;
        b_mem_data = 16'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_mem_read, o_mem_address, o_tx_data, o_tx_start, o_busy, o_done} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {o_mem_read, o_mem_address, o_tx_data, o_tx_start, o_busy, o_done});
        end
        checks++;
        if ({b_mem_read, b_mem_address, b_tx_data, b_tx_start, b_busy, b_done} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs_small: got %h expected 0",
                     {b_mem_read, b_mem_address, b_tx_data, b_tx_start, b_busy, b_done});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Runs one complete dump and compares the stream, reads and done pulses.
    task automatic run_dump(input string name, input bit check_lat, input int budget,
                            input bit restart);
        int b0, a0, d0, mv0, wv0, cyc;
        bit pulsed;
        b0 = got_b.size(); a0 = got_a.size(); d0 = done_cnt;
        mv0 = mr_viol; wv0 = wait_viol;
        pulsed = 1'b0;
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        if (check_lat) begin
            checks++;
            if ({o_mem_read, o_busy, o_mem_address} !== {2'b11, 32'd0}) begin
                errors++;
                $display("FAIL %s read_latency: got rd=%b busy=%b addr=%0d expected rd=1 busy=1 addr=0",
                         name, o_mem_read, o_busy, o_mem_address);
            end
            @(negedge clk);
            checks++;
            if ({o_mem_read, o_tx_start} !== 2'b00) begin
                errors++;
                $display("FAIL %s capture_cycle: got rd=%b txs=%b expected 0 0", name, o_mem_read, o_tx_start);
            end
            @(negedge clk);
            checks++;
            if ({o_tx_start, o_tx_data} !== {1'b1, exp_byte(0)}) begin
                errors++;
                $display("FAIL %s first_tx: got txs=%b data=%h expected txs=1 data=%h",
                         name, o_tx_start, o_tx_data, exp_byte(0));
            end
        end
        cyc = 0;
        while (done_cnt == d0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (restart && !pulsed && (got_a.size() - a0 >= 8)) begin
                i_start = 1'b1;
                pulsed  = 1'b1;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d expected 1 (cycles %0d)", name, done_cnt - d0, cyc);
        end
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after: got %b expected 0", name, o_busy);
        end
        checks++;
        if (got_b.size() - b0 != NBYTES) begin
            errors++;
            $display("FAIL %s byte_count: got %0d expected %0d", name, got_b.size() - b0, NBYTES);
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                checks++;
                if (got_b[b0 + k] !== exp_byte(k)) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %h expected %h", name, k, got_b[b0 + k], exp_byte(k));
                end
            end
        end
        checks++;
        if (got_a.size() - a0 != DEPTH) begin
            errors++;
            $display("FAIL %s read_count: got %0d expected %0d", name, got_a.size() - a0, DEPTH);
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                checks++;
                if (got_a[a0 + k] != k) begin
                    errors++;
                    $display("FAIL %s read_addr[%0d]: got %0d expected %0d", name, k, got_a[a0 + k], k);
                end
            end
        end
        checks++;
        if (mr_viol != mv0 || wait_viol != wv0) begin
            errors++;
            $display("FAIL %s handshake: got memread_runs=%0d wait_faults=%0d expected 0 0",
                     name, mr_viol - mv0, wait_viol - wv0);
        end
    endtask

    task automatic test_identity_image();
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'(i);
        tx_delay = 1;
        run_dump("identity", 1'b1, 1000, 1'b0);
    endtask

    task automatic test_deadbeef();
        logic [31:0] want;
        int b0;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        ram[5] = 32'hDEADBEEF;
        want = 32'hDEADBEEF;
        tx_delay = 1;
        b0 = got_b.size();
        run_dump("deadbeef", 1'b1, 1000, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_b.size() < b0 + 24 || got_b[b0 + 20 + k] !== want[31 - 8*k -: 8]) begin
                errors++;
                $display("FAIL deadbeef_word5[%0d]: got %h expected %h", k,
                         (got_b.size() < b0 + 24) ? 8'hxx : got_b[b0 + 20 + k], want[31 - 8*k -: 8]);
            end
        end
    endtask

    task automatic test_slow_tx();
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'(i);
        tx_delay = 20;
        run_dump("slow_tx", 1'b0, 4000, 1'b0);
    endtask

    task automatic test_spurious_inputs();
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        tx_delay = $urandom_range(1, 4);
        inj_idle = 1'b1;
        repeat (4) @(negedge clk);
        inj_read = 1'b1;
        run_dump("spurious", 1'b0, 2000, 1'b1);
        inj_idle = 1'b0;
        inj_read = 1'b0;
    endtask

    task automatic test_reset_mid_dump();
        int b0, cyc;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        ram[10] = {8'h80 | 8'($urandom), 24'($urandom)};
        tx_delay = 6;
        b0 = got_b.size();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
        cyc = 0;
        while (got_b.size() - b0 < 41 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({o_busy, o_mem_address, o_tx_data} !== {1'b1, 32'd10, ram[10][31:24]}) begin
            errors++;
            $display("FAIL midreset_pre: got busy=%b addr=%0d data=%h expected busy=1 addr=10 data=%h",
                     o_busy, o_mem_address, o_tx_data, ram[10][31:24]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({o_mem_read, o_mem_address, o_tx_data, o_tx_start, o_busy, o_done} !== 44'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h expected 0",
                     {o_mem_read, o_mem_address, o_tx_data, o_tx_start, o_busy, o_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_mem_read, o_tx_start} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_no_resume: got busy=%b rd=%b txs=%b expected 0 0 0",
                     o_busy, o_mem_read, o_tx_start);
        end
        tx_delay = 2;
        run_dump("after_reset", 1'b1, 2000, 1'b0);
    endtask

    task automatic test_small_config();
        logic [7:0] gb[$];
        int         ga[$];
        int         dn, cnt;
        bit         wt;
        logic [7:0] want;
        for (int i = 0; i < 4; i++) ramb[i] = 16'($urandom);
        dn = 0; cnt = 0; wt = 1'b0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            b_tx_done = 1'b0;
            if (b_mem_read) begin
                ga.push_back(int'(b_mem_address));
                b_mem_data = ramb[b_mem_address[1:0]];
            end
            if (b_done) dn++;
            if (wt) begin
                if (cnt > 0) cnt--;
                if (cnt == 0) begin
                    b_tx_done = 1'b1;
                    wt = 1'b0;
                end
            end
            if (b_tx_start) begin
                gb.push_back(b_tx_data);
                wt = 1'b1;
                cnt = 2;
            end
            @(negedge clk);
        end
        checks++;
        if (dn != 1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_done: got pulses=%0d busy=%b expected 1 0", dn, b_busy);
        end
        checks++;
        if (gb.size() != 8) begin
            errors++;
            $display("FAIL small_byte_count: got %0d expected 8", gb.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                want = 8'(ramb[k / 2] >> (8 * (1 - (k % 2))));
                checks++;
                if (gb[k] !== want) begin
                    errors++;
                    $display("FAIL small_byte[%0d]: got %h expected %h", k, gb[k], want);
                end
            end
        end
        checks++;
        if (ga.size() != 4) begin
            errors++;
            $display("FAIL small_read_count: got %0d expected 4", ga.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ga[k] != k) begin
                    errors++;
                    $display("FAIL small_read_addr[%0d]: got %0d expected %0d", k, ga[k], k);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity_image();
        test_deadbeef();
        test_slow_tx();
        test_spurious_inputs();
        test_reset_mid_dump();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
